// File: rtl/onchip_mem_frame_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// onchip_mem_frame_reader : streams a word range of on-chip memory with framing
// Revision: 1.0
// ---------------------------------------------------------------------------
module onchip_mem_frame_reader #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_start_in,
  input  logic [31:0]       start_addr_in,
  input  logic [31:0]       to_read_byte_in,
  input  logic [31:0]       one_frame_byte_in,
  output logic              read_done_out,
  output logic              busy_out,
  output logic              mem_chip_select,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_read_valid,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [DATA_W-1:0] st_data,
  output logic              st_sof,
  output logic              st_eof
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   C_DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [26:0]       total_q, frame_q, issued_q, deliv_q, fcnt_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [CW-1:0]     outst_q, count_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic              mem_read_q, cs_q, busy_q, done_q;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];

  logic [32:0] w_tot_sum, w_frm_sum;
  logic [26:0] w_total, w_frame;
  logic [CW:0] w_credit;
  logic        w_push, w_pop, w_issue, w_last;
  logic        w_unused;

  // Byte counts round up to whole 32-byte words; a zero frame size means one frame.
  assign w_tot_sum = {1'b0, to_read_byte_in} + 33'd31;
  assign w_frm_sum = {1'b0, one_frame_byte_in} + 33'd31;
  assign w_total   = w_tot_sum[31:5];
  assign w_frame   = (w_frm_sum[31:5] == 27'd0) ? w_total : w_frm_sum[31:5];
  assign w_unused  = ^{start_addr_in[31:ADDR_W+5], start_addr_in[4:0],
                       w_tot_sum[32], w_tot_sum[4:0], w_frm_sum[32], w_frm_sum[4:0]};

  assign w_credit = {1'b0, count_q} + {1'b0, outst_q};
  assign w_push   = mem_read_valid && (state_q != S_IDLE);
  assign w_pop    = st_valid && st_ready;
  assign w_issue  = (state_q == S_READ) && (issued_q != total_q) && (w_credit < C_DEPTH);
  assign w_last   = (deliv_q == total_q - 27'd1);

  assign st_valid = (count_q != '0);
  assign st_data  = fifo_q[rd_ptr_q];
  assign st_sof   = st_valid && (fcnt_q == 27'd0);
  assign st_eof   = st_valid && ((fcnt_q == frame_q - 27'd1) || w_last);

  assign read_done_out   = done_q;
  assign busy_out        = busy_q;
  assign mem_chip_select = cs_q;
  assign mem_read        = mem_read_q;
  assign mem_addr        = addr_q;

  always_ff @(posedge clk) begin
    if (w_push) fifo_q[wr_ptr_q] <= mem_read_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      total_q    <= '0;
      frame_q    <= '0;
      issued_q   <= '0;
      deliv_q    <= '0;
      fcnt_q     <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      outst_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_read_q <= 1'b0;
      cs_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      mem_read_q <= w_issue;
      cs_q       <= w_issue;
      if (w_issue) begin
        addr_q   <= base_q + issued_q[ADDR_W-1:0];
        issued_q <= issued_q + 27'd1;
      end
      // Credits cover both words in the FIFO and words still in the memory pipe.
      case ({w_issue, w_push})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        deliv_q  <= deliv_q + 27'd1;
        fcnt_q   <= st_eof ? 27'd0 : fcnt_q + 27'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (read_start_in) begin
            total_q  <= w_total;
            frame_q  <= w_frame;
            base_q   <= start_addr_in[ADDR_W+4:5];
            issued_q <= '0;
            deliv_q  <= '0;
            fcnt_q   <= '0;
            busy_q   <= 1'b1;
            if (w_total == 27'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          if (issued_q == total_q) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (outst_q == '0 && count_q == '0 && deliv_q == total_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && count_q == C_FULL));
`endif

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_frame_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_onchip_mem_frame_reader : randomized bench with a word-list reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_onchip_mem_frame_reader;

  localparam int MEM_LAT = 3;
  localparam int DEPTH   = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         read_start_in = 1'b0;
  logic [31:0]  start_addr_in = '0, to_read_byte_in = '0, one_frame_byte_in = '0;
  logic         read_done_out, busy_out, mem_chip_select, mem_read;
  logic [12:0]  mem_addr;
  logic         mem_read_valid;
  logic [255:0] mem_read_data;
  logic         st_valid, st_ready = 1'b1, st_sof, st_eof;
  logic [255:0] st_data;

  onchip_mem_frame_reader #(.DATA_W(256), .ADDR_W(13), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .read_start_in(read_start_in), .start_addr_in(start_addr_in),
    .to_read_byte_in(to_read_byte_in), .one_frame_byte_in(one_frame_byte_in),
    .read_done_out(read_done_out), .busy_out(busy_out), .mem_chip_select(mem_chip_select),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_read_valid(mem_read_valid),
    .mem_read_data(mem_read_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_data(st_data), .st_sof(st_sof), .st_eof(st_eof));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [255:0] mem_word(input int a);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = {a[15:0], 8'(i), 8'h5A} ^ (a * 32'h9E3779B1);
    return w;
  endfunction

  // Fixed-latency memory: data for a request appears MEM_LAT cycles later.
  logic        pv [MEM_LAT];
  logic [12:0] pa [MEM_LAT];
  always @(posedge clk) begin
    pv[0] <= mem_read && mem_chip_select;
    pa[0] <= mem_addr;
    for (int k = 1; k < MEM_LAT; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
  end
  assign mem_read_valid = pv[MEM_LAT-1];
  assign mem_read_data  = pv[MEM_LAT-1] ? mem_word(int'(pa[MEM_LAT-1])) : '0;

  logic [255:0] got_data[$];
  bit           got_sof[$], got_eof[$];
  int           addrs[$];
  int           reads, acc, run, maxrun, maxfly, done_cnt, done_cyc;
  bit           prev_stall;
  logic [255:0] p_data;
  logic         p_sof, p_eof;

  task automatic clear_mon();
    got_data.delete(); got_sof.delete(); got_eof.delete(); addrs.delete();
    reads = 0; acc = 0; run = 0; maxrun = 0; maxfly = 0; done_cnt = 0; done_cyc = 0;
    prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      run = 0;
    end else begin
      if (mem_read) begin
        reads++; addrs.push_back(int'(mem_addr)); run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (prev_stall) begin
        checks++;
        if (st_data !== p_data || st_sof !== p_sof || st_eof !== p_eof) begin
          errors++;
          $display("FAIL stall_hold: sof/eof %b%b required %b%b or data changed", st_sof, st_eof, p_sof, p_eof);
        end
      end
      prev_stall = st_valid && !st_ready;
      p_data = st_data; p_sof = st_sof; p_eof = st_eof;
      if (st_valid && st_ready) begin
        got_data.push_back(st_data); got_sof.push_back(st_sof); got_eof.push_back(st_eof);
        acc++;
      end
      if (reads - acc > maxfly) maxfly = reads - acc;
      if (read_done_out) begin
        done_cnt++; done_cyc = cyc;
      end
    end
  end

  function automatic int words_of(input logic [31:0] bytes);
    return int'((longint'(bytes) + 31) / 32);
  endfunction

  int start_cyc;

  // mode 0: ready always high; mode 1: random ready with a 20-cycle low stretch.
  task automatic run_xfer(input string nm, input logic [31:0] addr, input logic [31:0] bytes,
                          input logic [31:0] frame, input int mode, input int inj);
    clear_mon();
    @(posedge clk); #1;
    start_addr_in = addr; to_read_byte_in = bytes; one_frame_byte_in = frame;
    read_start_in = 1'b1;
    @(posedge clk); #1;
    read_start_in = 1'b0;
    start_cyc = cyc;
    for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
      @(posedge clk); #1;
      if (mode == 1) st_ready = (n >= 10 && n < 30) ? 1'b0 : 1'($urandom_range(0, 1));
      else st_ready = 1'b1;
      if (n == inj) begin
        read_start_in = 1'b1; start_addr_in = 32'h0010_0000;
        to_read_byte_in = 32'd32; one_frame_byte_in = 32'd0;
      end else read_start_in = 1'b0;
    end
    read_start_in = 1'b0;
    st_ready = 1'b1;
    checks++;
    if (done_cnt == 0) begin
      errors++; $display("FAIL %s_timeout: done pulses %0d required 1", nm, done_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_out !== 1'b0) begin
      errors++; $display("FAIL %s_busy_after: busy %b required 0", nm, busy_out);
    end
  endtask

  task automatic check_words(input string nm, input logic [31:0] addr, input logic [31:0] bytes,
                             input logic [31:0] frame);
    int total, fw, base, n;
    logic [255:0] ed;
    bit es, ee;
    total = words_of(bytes);
    fw    = (words_of(frame) == 0) ? total : words_of(frame);
    base  = int'(addr[17:5]);
    checks++;
    if (got_data.size() != total) begin
      errors++; $display("FAIL %s_count: words %0d required %0d", nm, got_data.size(), total);
    end
    n = (got_data.size() < total) ? got_data.size() : total;
    for (int i = 0; i < n; i++) begin
      ed = mem_word((base + i) % 8192);
      es = (i % fw) == 0;
      ee = ((i % fw) == fw - 1) || (i == total - 1);
      checks++;
      if (got_data[i] !== ed || got_sof[i] !== es || got_eof[i] !== ee) begin
        errors++;
        $display("FAIL %s_word%0d: data %h sof %b eof %b required data %h sof %b eof %b",
                 nm, i, got_data[i][31:0], got_sof[i], got_eof[i], ed[31:0], es, ee);
      end
    end
    checks++;
    if (addrs.size() != total) begin
      errors++; $display("FAIL %s_reads: mem_read cycles %0d required %0d", nm, addrs.size(), total);
    end
    for (int i = 0; i < addrs.size() && i < total; i++) begin
      checks++;
      if (addrs[i] != (base + i) % 8192) begin
        errors++; $display("FAIL %s_addr%0d: mem_addr %0d required %0d", nm, i, addrs[i], (base + i) % 8192);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL %s_done: done pulses %0d required 1", nm, done_cnt);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if ({read_done_out, busy_out, mem_chip_select, mem_read, st_valid, st_sof, st_eof} !== 7'b0 ||
        mem_addr !== 13'd0) begin
      errors++;
      $display("FAIL %s: done/busy/cs/rd/valid/sof/eof %b%b%b%b%b%b%b addr %0d required all 0",
               nm, read_done_out, busy_out, mem_chip_select, mem_read, st_valid, st_sof, st_eof, mem_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset_released");
  endtask

  task automatic test_basic();
    run_xfer("basic", 32'h40, 32'd256, 32'd64, 0, -1);
    check_words("basic", 32'h40, 32'd256, 32'd64);
    checks++;
    if (maxrun != 8) begin
      errors++; $display("FAIL basic_consecutive: longest mem_read run %0d required 8", maxrun);
    end
  endtask

  task automatic test_nonaligned();
    logic [31:0] a;
    a = $urandom;
    run_xfer("nonaligned", a, 32'd100, 32'd40, 0, -1);
    check_words("nonaligned", a, 32'd100, 32'd40);
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    a = $urandom;
    run_xfer("backpressure", a, 32'd1024, 32'd96, 1, -1);
    check_words("backpressure", a, 32'd1024, 32'd96);
    checks++;
    if (maxfly > DEPTH) begin
      errors++; $display("FAIL backpressure_inflight: max in flight %0d required <= %0d", maxfly, DEPTH);
    end
  endtask

  task automatic test_wrap();
    run_xfer("wrap", 32'h3FFE0, 32'd96, 32'd0, 0, -1);
    check_words("wrap", 32'h3FFE0, 32'd96, 32'd0);
  endtask

  task automatic test_zero();
    run_xfer("zero", 32'h80, 32'd0, 32'd64, 0, -1);
    checks++;
    if (reads != 0 || done_cnt != 1 || done_cyc - start_cyc > 2 || done_cyc < start_cyc) begin
      errors++;
      $display("FAIL zero_len: reads %0d done %0d delay %0d required reads 0 done 1 delay <= 2",
               reads, done_cnt, done_cyc - start_cyc);
    end
  endtask

  task automatic test_ignore_start();
    run_xfer("ignore", 32'h1000, 32'd1024, 32'd128, 0, 5);
    check_words("ignore", 32'h1000, 32'd1024, 32'd128);
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mon();
    @(posedge clk); #1;
    start_addr_in = 32'h2000; to_read_byte_in = 32'd1024; one_frame_byte_in = 32'd128;
    read_start_in = 1'b1;
    @(posedge clk); #1;
    read_start_in = 1'b0;
    n = 0;
    while (acc < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (acc < 5) begin
      errors++; $display("FAIL reset_mid_progress: accepted %0d required 5", acc);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_async");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL reset_mid_nodone: done pulses %0d busy %b required 0 0", done_cnt, busy_out);
    end
    run_xfer("after_reset", 32'h60, 32'd320, 32'd96, 0, -1);
    check_words("after_reset", 32'h60, 32'd320, 32'd96);
  endtask

  task automatic test_random();
    logic [31:0] a, b, f;
    int m;
    for (int t = 0; t < 5; t++) begin
      a = $urandom;
      b = 32'($urandom_range(1, 700));
      f = 32'($urandom_range(0, 160));
      m = int'($urandom_range(0, 1));
      run_xfer($sformatf("rand%0d", t), a, b, f, m, -1);
      check_words($sformatf("rand%0d", t), a, b, f);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_nonaligned();
    test_backpressure();
    test_wrap();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
